// File: rtl/shifter_pkg.sv
// Shared types and defaults for the iterative multi-bit shifter.
// Holds the operation codes, the controller state encoding and the
// default datapath sizes used by multi_shift_unit and shift_step_m.
package shifter_pkg;

   localparam int DEF_WORD_SIZE = 16;
   localparam int DEF_CNT_WIDTH = 4;

   typedef enum logic [2:0] {
      SRA  = 3'd0,
      RRC  = 3'd1,
      SRL  = 3'd2,
      SLL  = 3'd3,
      RLC  = 3'd4,
      ROR  = 3'd5,
      ROL  = 3'd6,
      RSVD = 3'd7
   } shift_func_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } msu_state_e;

endpackage

// File: rtl/shift_step_m.sv
// Single bit-step of the shifter/rotator, purely combinational.
// Works on the full word or, in byte mode, on the low half only; the
// upper half of the produced word is always zero in byte mode.
module shift_step_m
   import shifter_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE
) (
   input  shift_func_e          i_func,
   input  logic                 i_byteOp,
   input  logic [WORD_SIZE-1:0] i_work,
   input  logic                 i_carry,
   output logic [WORD_SIZE-1:0] o_work,
   output logic                 o_carry
);

   localparam int HALF = WORD_SIZE / 2;

   logic                 w_msb;
   logic                 w_lsb;
   logic                 w_ins;
   logic                 w_left;
   logic [WORD_SIZE-1:0] w_fullRight;
   logic [WORD_SIZE-1:0] w_fullLeft;
   logic [HALF-1:0]      w_halfRight;
   logic [HALF-1:0]      w_halfLeft;

   // Every mode reduces to a direction plus the bit shifted into the vacated end
   always_comb begin
      w_msb  = i_byteOp ? i_work[HALF-1] : i_work[WORD_SIZE-1];
      w_lsb  = i_work[0];
      w_left = 1'b0;
      w_ins  = w_msb;
      case (i_func)
         SRA: begin
            w_left = 1'b0;
            w_ins  = w_msb;
         end
         RRC: begin
            w_left = 1'b0;
            w_ins  = i_carry;
         end
         SRL: begin
            w_left = 1'b0;
            w_ins  = 1'b0;
         end
         SLL: begin
            w_left = 1'b1;
            w_ins  = 1'b0;
         end
         RLC: begin
            w_left = 1'b1;
            w_ins  = i_carry;
         end
         ROR: begin
            w_left = 1'b0;
            w_ins  = w_lsb;
         end
         ROL: begin
            w_left = 1'b1;
            w_ins  = w_msb;
         end
         default: begin
            w_left = 1'b0;
            w_ins  = w_msb;
         end
      endcase
   end

   // Candidate shifted words for both widths and both directions
   assign w_fullRight = {w_ins, i_work[WORD_SIZE-1:1]};
   assign w_fullLeft  = {i_work[WORD_SIZE-2:0], w_ins};
   assign w_halfRight = {w_ins, i_work[HALF-1:1]};
   assign w_halfLeft  = {i_work[HALF-2:0], w_ins};

   // Pick the word for the active width; the carry takes the bit that falls off
   always_comb begin
      o_carry = w_left ? w_msb : w_lsb;
      if (i_byteOp) begin
         o_work = {{HALF{1'b0}}, (w_left ? w_halfLeft : w_halfRight)};
      end else begin
         o_work = w_left ? w_fullLeft : w_fullRight;
      end
   end

endmodule

// File: rtl/multi_shift_unit.sv
// Iterative multi-bit shifter/rotator with a start/done handshake.
// One bit-step per clock on a registered working word; result, carry,
// zero and negative feed the ALU result mux and status-register update.
module multi_shift_unit
   import shifter_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2:0]           func,
   input  logic                 byte_op,
   input  logic [CNT_WIDTH-1:0] count,
   input  logic [WORD_SIZE-1:0] src,
   input  logic                 carry_in,
   input  logic                 flush,
   output logic                 busy,
   output logic                 done,
   output logic [WORD_SIZE-1:0] result,
   output logic                 carry_out,
   output logic                 zero,
   output logic                 negative
);

   localparam int HALF = WORD_SIZE / 2;

   msu_state_e           r_state;
   logic [WORD_SIZE-1:0] r_work;
   logic                 r_carry;
   logic [CNT_WIDTH-1:0] r_cnt;
   shift_func_e          r_func;
   logic                 r_byteOp;

   logic                 w_accept;
   logic [WORD_SIZE-1:0] w_srcMasked;
   logic [WORD_SIZE-1:0] w_stepWork;
   logic                 w_stepCarry;

   // A new request is taken only when no shift is in flight and no abort is pending
   assign w_accept    = ((r_state == IDLE) || (r_state == DONE)) && start && !flush;
   assign w_srcMasked = byte_op ? {{HALF{1'b0}}, src[HALF-1:0]} : src;

   shift_step_m #(
      .WORD_SIZE (WORD_SIZE)
   ) u_step (
      .i_func   (r_func),
      .i_byteOp (r_byteOp),
      .i_work   (r_work),
      .i_carry  (r_carry),
      .o_work   (w_stepWork),
      .o_carry  (w_stepCarry)
   );

   // Controller and working registers; flush freezes the datapath and returns to IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_work   <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_func   <= SRA;
         r_byteOp <= 1'b0;
      end else if (flush) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (w_accept) begin
                  r_work   <= w_srcMasked;
                  r_carry  <= carry_in;
                  r_cnt    <= count;
                  r_func   <= shift_func_e'(func);
                  r_byteOp <= byte_op;
                  r_state  <= (count != '0) ? SHIFT : DONE;
               end else begin
                  r_state <= IDLE;
               end
            end
            SHIFT: begin
               r_work  <= w_stepWork;
               r_carry <= w_stepCarry;
               r_cnt   <= r_cnt - CNT_WIDTH'(1);
               if (r_cnt == CNT_WIDTH'(1)) begin
                  r_state <= DONE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Handshake flags decode straight from the state register, so they are glitch-free
   assign busy      = (r_state == SHIFT);
   assign done      = (r_state == DONE);
   assign result    = r_work;
   assign carry_out = r_carry;

   // Status flags look only at the active part of the working word
   always_comb begin
      if (r_byteOp) begin
         zero     = (r_work[HALF-1:0] == '0);
         negative = r_work[HALF-1];
      end else begin
         zero     = (r_work == '0);
         negative = r_work[WORD_SIZE-1];
      end
   end

endmodule

// File: tb/tb_multi_shift_unit.sv
// Directed bench for multi_shift_unit: hand-computed vectors for every mode,
// byte mode, zero count, back-to-back restart, ignored start, flush and reset.
module tb_multi_shift_unit;
   import shifter_pkg::*;

   localparam int WS = 16;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [2:0]    func = '0;
   logic          byte_op = 1'b0;
   logic [CW-1:0] count = '0;
   logic [WS-1:0] src = '0;
   logic          carry_in = 1'b0;
   logic          flush = 1'b0;
   logic          busy;
   logic          done;
   logic [WS-1:0] result;
   logic          carry_out;
   logic          zero;
   logic          negative;

   int nChecks = 0;
   int nPass = 0;
   int nFail = 0;

   multi_shift_unit #(
      .WORD_SIZE (WS),
      .CNT_WIDTH (CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .func      (func),
      .byte_op   (byte_op),
      .count     (count),
      .src       (src),
      .carry_in  (carry_in),
      .flush     (flush),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .zero      (zero),
      .negative  (negative)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   // Hard stop in case the sequence itself wedges
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete, observed timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      assert (observed === expected) nPass++;
      else begin
         nFail++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkResult(input string tag, input logic [WS-1:0] expRes, input logic expCarry,
                              input logic expZero, input logic expNeg);
      checkOutput({tag, ".result"}, 32'(result), 32'(expRes));
      checkOutput({tag, ".carry"}, 32'(carry_out), 32'(expCarry));
      checkOutput({tag, ".zero"}, 32'(zero), 32'(expZero));
      checkOutput({tag, ".negative"}, 32'(negative), 32'(expNeg));
   endtask

   task automatic checkResetValues(input string tag);
      checkResult(tag, 16'h0000, 1'b0, 1'b1, 1'b0);
      checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
      checkOutput({tag, ".done"}, 32'(done), 32'd0);
   endtask

   // Drive one request for a single clock; returns just after the sampling edge
   task automatic applyStimulus(input logic [2:0] f, input logic b, input logic [CW-1:0] n,
                                input logic [WS-1:0] s, input logic ci);
      func     = f;
      byte_op  = b;
      count    = n;
      src      = s;
      carry_in = ci;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
   endtask

   // Count falling edges until done, bounded; checks latency and busy/done exclusivity
   task automatic waitDone(input string tag, input int maxCycles, input int expCycles);
      int cycles;
      bit found;
      cycles = 0;
      found  = 1'b0;
      while (!found && cycles < maxCycles) begin
         @(negedge clk);
         cycles++;
         if (done) found = 1'b1;
      end
      if (found) begin
         checkOutput({tag, ".latency"}, 32'(cycles), 32'(expCycles));
         checkOutput({tag, ".busyAtDone"}, 32'(busy), 32'd0);
      end else begin
         checkOutput({tag, ".timeout"}, 32'(done), 32'd1);
      end
   endtask

   initial begin
      // Reset state
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkResetValues("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // SRA 0x8001 by 3 -> 0xF000
      applyStimulus(3'(SRA), 1'b0, 4'd3, 16'h8001, 1'b0);
      waitDone("sra3", 40, 4);
      checkResult("sra3", 16'hF000, 1'b0, 1'b0, 1'b1);

      // RRC 0x0001 with carry in by 1 -> 0x8000, carry 1
      applyStimulus(3'(RRC), 1'b0, 4'd1, 16'h0001, 1'b1);
      waitDone("rrc1", 40, 2);
      checkResult("rrc1", 16'h8000, 1'b1, 1'b0, 1'b1);

      // Zero count passes operand and carry straight through
      applyStimulus(3'(RRC), 1'b0, 4'd0, 16'h0001, 1'b1);
      waitDone("rrc0", 40, 1);
      checkResult("rrc0", 16'h0001, 1'b1, 1'b0, 1'b0);

      // Byte SRA 0xAB81 by 2 -> low byte 0x81 -> 0xE0
      applyStimulus(3'(SRA), 1'b1, 4'd2, 16'hAB81, 1'b0);
      waitDone("byteSra2", 40, 3);
      checkResult("byteSra2", 16'h00E0, 1'b0, 1'b0, 1'b1);

      // Byte RLC 0xAB81 by 1 -> 0x02, carry from byte MSB
      applyStimulus(3'(RLC), 1'b1, 4'd1, 16'hAB81, 1'b0);
      waitDone("byteRlc1", 40, 2);
      checkResult("byteRlc1", 16'h0002, 1'b1, 1'b0, 1'b0);

      // Byte ROL 0x1280 by 1 -> low byte 0x80 rotates to 0x01
      applyStimulus(3'(ROL), 1'b1, 4'd1, 16'h1280, 1'b0);
      waitDone("byteRol1", 40, 2);
      checkResult("byteRol1", 16'h0001, 1'b1, 1'b0, 1'b0);

      // Byte mode with zero count clears the upper half
      applyStimulus(3'(SRL), 1'b1, 4'd0, 16'hFF12, 1'b0);
      waitDone("byteCnt0", 40, 1);
      checkResult("byteCnt0", 16'h0012, 1'b0, 1'b0, 1'b0);

      // SRL to zero sets the zero flag
      applyStimulus(3'(SRL), 1'b0, 4'd1, 16'h0001, 1'b0);
      waitDone("srl1", 40, 2);
      checkResult("srl1", 16'h0000, 1'b1, 1'b1, 1'b0);

      // Reserved code behaves as SRA
      applyStimulus(3'(RSVD), 1'b0, 4'd1, 16'h8000, 1'b1);
      waitDone("rsvd1", 40, 2);
      checkResult("rsvd1", 16'hC000, 1'b0, 1'b0, 1'b1);

      // ROR 0x0001 by 2 -> 0x4000, last bit out 0
      applyStimulus(3'(ROR), 1'b0, 4'd2, 16'h0001, 1'b0);
      waitDone("ror2", 40, 3);
      checkResult("ror2", 16'h4000, 1'b0, 1'b0, 1'b0);

      // Back-to-back: SLL 0x0003 by max count, then ROL issued in the done cycle
      applyStimulus(3'(SLL), 1'b0, 4'd15, 16'h0003, 1'b0);
      waitDone("sll15", 40, 16);
      checkResult("sll15", 16'h8000, 1'b1, 1'b0, 1'b1);
      applyStimulus(3'(ROL), 1'b0, 4'd1, 16'h8000, 1'b0);
      @(negedge clk);
      checkOutput("b2b.noGapBusy", 32'(busy), 32'd1);
      waitDone("b2bRol", 40, 1);
      checkResult("b2bRol", 16'h0001, 1'b1, 1'b0, 1'b0);

      // Start while shifting is ignored
      applyStimulus(3'(SRL), 1'b0, 4'd4, 16'h8000, 1'b0);
      @(negedge clk);
      checkOutput("ignore.busy", 32'(busy), 32'd1);
      applyStimulus(3'(SLL), 1'b0, 4'd1, 16'hFFFF, 1'b1);
      waitDone("ignore", 40, 4);
      checkResult("ignore", 16'h0800, 1'b0, 1'b0, 1'b0);

      // Flush mid-shift: back to idle, datapath frozen, no done
      applyStimulus(3'(SRL), 1'b0, 4'd8, 16'hFF00, 1'b0);
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      checkOutput("flush.busy", 32'(busy), 32'd0);
      checkOutput("flush.done", 32'(done), 32'd0);
      checkOutput("flush.result", 32'(result), 32'h7F80);
      checkOutput("flush.carry", 32'(carry_out), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("flush.noDone", 32'(done), 32'd0);
      end

      // Asynchronous reset mid-shift takes effect without a clock edge
      applyStimulus(3'(SRA), 1'b0, 4'd10, 16'h8001, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetValues("asyncReset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("afterReset.done", 32'(done), 32'd0);

      // Normal operation after reset release
      applyStimulus(3'(ROR), 1'b0, 4'd1, 16'h0001, 1'b0);
      waitDone("postReset", 40, 2);
      checkResult("postReset", 16'h8000, 1'b1, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/multi_shift_unit.md
# multi_shift_unit

Iterative multi-bit shifter/rotator for the multi-cycle datapath. It generalises the single-step shifter to a programmable shift count, more modes, and a start/done handshake. It performs one bit-step per clock on a registered working word and reports result, carry, zero and negative flags to the ALU result mux and status-register update logic.

## Interface
Parameters:
- WORD_SIZE, 16, datapath width; must be even, ≥4
- CNT_WIDTH, 4, width of shift count; max count 2^CNT_WIDTH−1

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- start  in  1  request; sampled only when accept condition holds
- func  in  3  operation code (shift_func_e)
- byte_op  in  1  1 = operate on low WORD_SIZE/2 bits
- count  in  CNT_WIDTH  number of bit-steps
- src  in  WORD_SIZE  operand
- carry_in  in  1  carry flag at issue
- flush  in  1  synchronous abort to IDLE
- busy  out  1  1 while shifting
- done  out  1  one-cycle completion pulse
- result  out  WORD_SIZE  registered result
- carry_out  out  1  registered carry
- zero  out  1  result (active part) == 0
- negative  out  1  MSB of active part of result

## Operation
- States: IDLE, SHIFT, DONE.
- Accept condition: state is IDLE or DONE, start=1, flush=0.
- On accept, latch the following:
  - work ← src; in byte mode, the upper half is cleared.
  - c ← carry_in.
  - cnt ← count; func and byte_op are also latched.
- Next state after accept: SHIFT if count≠0, else DONE.
- In SHIFT, each cycle:
  - Apply one step to work and c.
  - cnt ← cnt−1.
  - When cnt==1, the next state is DONE.
- Active part: bits [W−1:0], where W = WORD_SIZE, or WORD_SIZE/2 in byte mode. The upper half stays 0 in byte mode.
- Step per func (b = work active part, m = b[W−1]):
  - 0 SRA: b ← {m, b[W−1:1]}, c ← b[0]
  - 1 RRC: b ← {c, b[W−1:1]}, c ← b[0]
  - 2 SRL: b ← {0, b[W−1:1]}, c ← b[0]
  - 3 SLL: b ← {b[W−2:0], 0}, c ← m
  - 4 RLC: b ← {b[W−2:0], c}, c ← m
  - 5 ROR: b ← {b[0], b[W−1:1]}, c ← b[0]
  - 6 ROL: b ← {b[W−2:0], m}, c ← m
  - 7: reserved, behaves as SRA.
- No count clamping: counts ≥ W keep stepping (SRL/SLL reach 0; SRA saturates to sign fill).
- count=0: result = src (upper half cleared if byte_op), carry_out = carry_in.
- Outputs:
  - result = work; carry_out = c.
  - zero and negative are derived combinationally from registered work over the active part.
  - Values hold until the next accept.
- DONE lasts exactly one cycle unless a new start is accepted in it; otherwise the next state is IDLE.
- start while in SHIFT: ignored. There is no queueing.
- flush: from any state, the next state is IDLE. work/c hold their current values and no done pulse is issued. flush has priority over start.

## Timing
- Reset values:
  - state IDLE; busy 0; done 0.
  - result 0; carry_out 0; zero 1; negative 0.
  - cnt 0; latched func/byte_op 0.
- Reset mid-operation aborts immediately; no done pulse is produced.
- Start accepted at edge E0:
  - busy=1 from E0 to E(count) when count≥1.
  - done=1 for the cycle following E(count).
  - Latency is count+1 cycles from the start cycle to the done cycle; final values are valid with done.
- Back-to-back: start accepted during the DONE cycle gives a zero-bubble restart. The done pulse still shows in that cycle.
- busy and done are never both 1.

## Structure
- Package shifter_pkg:
  - shift_func_e (SRA, RRC, SRL, SLL, RLC, ROR, ROL, RSVD)
  - msu_state_e (IDLE, SHIFT, DONE)
  - default WORD_SIZE / CNT_WIDTH constants
- Sub-module shift_step_m: purely combinational single bit-step.
  - Inputs: func, byte_op, work, c. Outputs: next work, next c.
  - The FSM/counter in multi_shift_unit instantiates it once.

## Test plan
- Reset, then src=0x8001, func=SRA, count=3, byte_op=0 → done after 4 cycles; result 0xF000, carry_out 0, negative 1, zero 0.
- RRC with src=0x0001, carry_in=1, count=1 → result 0x8000, carry_out 1. Same with count=0 → result 0x0001, carry_out 1, done on the next cycle.
- Byte mode, src=0xAB81, SRA, count=2 → result 0x00E0, carry_out 0, negative 1. Same inputs with RLC, carry_in=0, count=1 → result 0x0002, carry_out 1.
- Back-to-back: SLL 0x0003 count=15, then start with ROL 0x8000 count=1 asserted in the DONE cycle:
  - first op → result 0x8000, carry_out 1
  - second op → result 0x0001, carry_out 1
  - no idle gap between the two operations
- start pulsed during SHIFT with a different operand → ignored; the first operation completes with unchanged result. flush mid-SHIFT → busy drops next cycle and no done pulse.
- rst_n asserted asynchronously mid-SHIFT → all outputs take reset values immediately. A new op after release completes normally.
